scan_decoder: RTL and testbench

Parametrised, registered successor to the team's combinational 2-to-4 binary decoder: SEL_W-bit select to one-hot 2**SEL_W output with enable.

---
 rtl/scan_decoder_pkg.sv | 27 ++
 rtl/scan_decoder_onehot_decode.sv | 16 +
 rtl/scan_decoder.sv | 146 ++++++++++++++
 tb/tb_scan_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared encodings for the scan decoder: mode field values and FSM states.
package scan_decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN,
        ST_SWEEP,
        ST_HOLD
    } state_t;

    // State that a given mode value asks the FSM to run in.
    function automatic state_t mode_state(input logic [1:0] m);
        case (m)
            MODE_DIRECT: mode_state = ST_DIRECT;
            MODE_SCAN:   mode_state = ST_SCAN;
            MODE_SWEEP:  mode_state = ST_SWEEP;
            default:     mode_state = ST_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
module onehot_decode #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [2**SEL_W-1:0] out
);

    // Set exactly the selected bit when enabled, otherwise all-zero.
    always_comb begin
        out = '0;
        if (en) out[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct, auto-scan, single-sweep and hold modes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [2**SEL_W-1:0] out,
    output logic [SEL_W-1:0]    idx,
    output logic                active,
    output logic                wrap,
    output logic                done
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = '1;

    state_t             state_q, state_d, tgt;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               act_q, act_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               lock_q, lock_d;   // a sweep finished; wait for mode to leave SWEEP
    logic [OUT_W-1:0]   out_q, out_d;

    // Output pattern is always derived from the next index and active flag,
    // so out can only ever be zero or the one-hot of idx.
    onehot_decode #(.SEL_W(SEL_W)) u_dec (
        .sel (idx_d),
        .en  (act_d),
        .out (out_d)
    );

    // State, position, dwell counter and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
            out_q   <= out_d;
        end
    end

    // Next-state, stepping and pulse generation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        lock_d  = lock_q;
        tgt     = mode_state(mode);

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            act_d   = 1'b0;
            cnt_d   = '0;
            lock_d  = 1'b0;
        end else begin
            if (mode != MODE_SWEEP) lock_d = 1'b0;
            if (state_q == ST_IDLE) begin
                // SCAN/SWEEP start producing output one cycle after entry;
                // DIRECT decodes immediately for single-cycle latency.
                if (!(mode == MODE_SWEEP && lock_q)) begin
                    state_d = tgt;
                    if (tgt == ST_DIRECT) begin
                        idx_d = sel;
                        act_d = 1'b1;
                    end
                end
            end else if (tgt != state_q) begin
                // Mode change: scanning modes always restart from position 0.
                state_d = tgt;
                case (tgt)
                    ST_DIRECT: begin
                        idx_d = sel;
                        act_d = 1'b1;
                    end
                    ST_SCAN, ST_SWEEP: begin
                        idx_d = '0;
                        act_d = 1'b1;
                        cnt_d = dwell;
                    end
                    default: ;
                endcase
            end else begin
                case (state_q)
                    ST_DIRECT: begin
                        idx_d = sel;
                        act_d = 1'b1;
                    end
                    ST_SCAN, ST_SWEEP: begin
                        if (!act_q) begin
                            idx_d = '0;
                            act_d = 1'b1;
                            cnt_d = dwell;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else if (state_q == ST_SWEEP && idx_q == IDX_MAX) begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            act_d   = 1'b0;
                            done_d  = 1'b1;
                            lock_d  = 1'b1;
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            cnt_d  = dwell;
                            wrap_d = (state_q == ST_SCAN) && (idx_q == IDX_MAX);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out    = out_q;
    assign idx    = idx_q;
    assign active = act_q;
    // Pulses are suppressed in any cycle the block is disabled or held in reset.
    assign wrap   = wrap_q & enable & ~reset;
    assign done   = done_q & enable & ~reset;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed + randomized checks of scan_decoder against arithmetic position formulas.
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    localparam int SEL_W   = 2;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 4;

    logic               clk = 1'b0;
    logic               reset, enable;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               active, wrap, done;

    int total = 0;
    int bad   = 0;

    scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .sel    (sel),
        .dwell  (dwell),
        .out    (out),
        .idx    (idx),
        .active (active),
        .wrap   (wrap),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and check the structural invariants of the outputs.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        e = active ? (32'd1 << idx) : 32'd0;
        chk("inv_active", {31'd0, active}, {31'd0, |out});
        chk("inv_onehot", {28'd0, out}, e);
        chk("inv_pulses", {31'd0, wrap & done}, 32'd0);
    endtask

    // Pass through IDLE, then request mode m (state changes on the second edge).
    task automatic start(input logic [1:0] m);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        mode   = m;
        tick();
    endtask

    function automatic logic [31:0] scan_pos(input int k, input int d);
        return 32'd1 << ((k / (d + 1)) % OUT_W);
    endfunction

    initial begin
        int d, s, p;

        // Reset dominates enable/mode.
        reset = 1'b1; enable = 1'b1; mode = MODE_SCAN; sel = '0; dwell = 8'd2;
        tick(); tick();
        chk("rst_out", {28'd0, out}, 32'd0);
        chk("rst_idx", {30'd0, idx}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        chk("scan_entry_idle", {28'd0, out}, 32'd0);
        tick();

        // SCAN, dwell=2: 3 cycles per bit, wrap once per 12-cycle period.
        for (int k = 0; k < 25; k++) begin
            chk("scan_d2_out", {28'd0, out}, scan_pos(k, 2));
            chk("scan_d2_wrap", {31'd0, wrap}, (k > 0 && k % 12 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Dwell changed mid-position: position 0 keeps 3 cycles, then 1 each.
        dwell = 8'd2;
        start(MODE_SCAN);
        tick();
        for (int k = 0; k < 11; k++) begin
            if (k == 1) dwell = 8'd0;
            p = (k < 3) ? 0 : (k - 2) % OUT_W;
            chk("scan_dchg_out", {28'd0, out}, 32'd1 << p);
            chk("scan_dchg_wrap", {31'd0, wrap}, (k >= 3 && p == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Randomized dwell scans.
        repeat (3) begin
            d = $urandom_range(0, 4);
            dwell = DWELL_W'(d);
            start(MODE_SCAN);
            tick();
            for (int k = 0; k <= 8 * (d + 1); k++) begin
                chk("scan_rnd_out", {28'd0, out}, scan_pos(k, d));
                chk("scan_rnd_wrap", {31'd0, wrap},
                    (k > 0 && k % (OUT_W * (d + 1)) == 0) ? 32'd1 : 32'd0);
                tick();
            end
        end

        // DIRECT: one cycle from enable/sel to out.
        enable = 1'b0;
        tick();
        chk("off_out", {28'd0, out}, 32'd0);
        enable = 1'b1; mode = MODE_DIRECT; sel = 2'd0;
        tick();
        chk("direct_en", {28'd0, out}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            sel = SEL_W'(i);
            tick();
            chk("direct_step", {28'd0, out}, 32'd1 << i);
            chk("direct_idx", {30'd0, idx}, i);
        end
        repeat (8) begin
            s = $urandom_range(0, OUT_W - 1);
            sel = SEL_W'(s);
            tick();
            chk("direct_rnd", {28'd0, out}, 32'd1 << s);
        end
        enable = 1'b0;
        tick();
        chk("direct_off_out", {28'd0, out}, 32'd0);
        chk("direct_off_idx", {30'd0, idx}, 32'd0);
        chk("direct_off_active", {31'd0, active}, 32'd0);

        // SWEEP: dwell=1 directed, then random dwells; no restart while mode stays.
        for (int t = 0; t < 3; t++) begin
            d = (t == 0) ? 1 : $urandom_range(0, 3);
            dwell = DWELL_W'(d);
            start(MODE_SWEEP);
            tick();
            for (int k = 0; k < OUT_W * (d + 1); k++) begin
                chk("sweep_out", {28'd0, out}, 32'd1 << (k / (d + 1)));
                chk("sweep_done_early", {31'd0, done}, 32'd0);
                chk("sweep_wrap", {31'd0, wrap}, 32'd0);
                tick();
            end
            chk("sweep_end_out", {28'd0, out}, 32'd0);
            chk("sweep_done", {31'd0, done}, 32'd1);
            repeat (6) begin
                tick();
                chk("sweep_norestart", {28'd0, out}, 32'd0);
                chk("sweep_done_once", {31'd0, done}, 32'd0);
            end
        end

        // HOLD freezes 0100; leaving HOLD for SCAN restarts at 0001.
        dwell = 8'd1;
        start(MODE_SCAN);
        tick();
        repeat (4) tick();
        chk("hold_pre", {28'd0, out}, 32'h4);
        mode = MODE_HOLD;
        repeat (10) begin
            tick();
            chk("hold_out", {28'd0, out}, 32'h4);
            chk("hold_idx", {30'd0, idx}, 32'd2);
        end
        mode = MODE_SCAN;
        tick();
        chk("hold_leave0", {28'd0, out}, 32'h1);
        tick();
        chk("hold_leave1", {28'd0, out}, 32'h1);
        tick();
        chk("hold_leave2", {28'd0, out}, 32'h2);

        // Reset mid-SCAN, then SCAN restarts at 0001.
        reset = 1'b1;
        tick();
        chk("rst_mid_out", {28'd0, out}, 32'd0);
        chk("rst_mid_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_mid_idle", {28'd0, out}, 32'd0);
        tick();
        chk("rst_mid_restart", {28'd0, out}, 32'h1);

        // HOLD entered from IDLE keeps out at zero.
        start(MODE_HOLD);
        repeat (4) begin
            tick();
            chk("hold_idle", {28'd0, out}, 32'd0);
        end

        // All-ones dwell: 256 cycles per position.
        dwell = 8'hFF;
        start(MODE_SCAN);
        tick();
        for (int k = 0; k <= 256; k++) begin
            if (k == 0 || k == 255 || k == 256)
                chk("dwell_max", {28'd0, out}, scan_pos(k, 255));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
